// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side and SPI_mstr16-side signals of the two-port SPI arbiter
interface spi_arbiter_if;
  logic req0, req1, lock0, lock1;
  logic [15:0] cmd0, cmd1;
  logic gnt0, gnt1, done0, done1;
  logic [15:0] rd_data;
  logic spi_wrt;
  logic [15:0] spi_cmd;
  logic spi_done;
  logic [15:0] spi_rd_data;
  logic timeout_err;
  modport slave (
    input req0, req1, lock0, lock1, cmd0, cmd1, spi_done, spi_rd_data,
    output gnt0, gnt1, done0, done1, rd_data, spi_wrt, spi_cmd, timeout_err
  );
  modport master (
    output req0, req1, lock0, lock1, cmd0, cmd1, spi_done, spi_rd_data,
    input gnt0, gnt1, done0, done1, rd_data, spi_wrt, spi_cmd, timeout_err
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI_mstr16 between two ports, with burst lock,
// idle gap between transactions, burst cap and done-timeout watchdog
module spi_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int MAX_BURST      = 10,
  parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  spi_arbiter_if.slave bus
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_n;
  logic owner, last, issue, issue_port, finish, keep, tmo_hit, gap_end;
  logic own_req, oth_req, own_lock, arb_w, held;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] burst_cnt;
  logic [15:0] tmo;
  assign own_req  = owner ? bus.req1 : bus.req0;
  assign oth_req  = owner ? bus.req0 : bus.req1;
  assign own_lock = owner ? bus.lock1 : bus.lock0;
  assign arb_w    = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign held     = bus.gnt0 | bus.gnt1;
  assign tmo_hit  = tmo == TMO_LAST;
  assign finish   = state == BUSY & (bus.spi_done | tmo_hit);
  assign keep     = own_lock & own_req & ~(burst_cnt == BURST_MAX & oth_req);
  assign gap_end  = state == GAP & gap_cnt == GAP_LAST;
  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_port = owner;
    case (state)
      IDLE: if (bus.req0 | bus.req1) begin
        issue      = 1'b1;
        issue_port = arb_w;
        state_n    = BUSY;
      end
      BUSY: if (finish) begin
        issue   = GAP_CYCLES == 0 & keep;
        state_n = GAP_CYCLES != 0 ? GAP : (keep ? BUSY : IDLE);
      end
      GAP: if (gap_end) begin
        issue   = held & own_req;
        state_n = (held & own_req) ? BUSY : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      last            <= 1'b1;
      burst_cnt       <= '0;
      gap_cnt         <= '0;
      tmo             <= '0;
      bus.gnt0        <= 1'b0;
      bus.gnt1        <= 1'b0;
      bus.done0       <= 1'b0;
      bus.done1       <= 1'b0;
      bus.rd_data     <= '0;
      bus.spi_wrt     <= 1'b0;
      bus.spi_cmd     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      bus.spi_wrt <= issue;
      bus.done0   <= finish & ~owner;
      bus.done1   <= finish & owner;
      tmo         <= (state == BUSY & ~finish) ? tmo + 16'd1 : 16'd0;
      gap_cnt     <= (state == GAP & ~gap_end) ? gap_cnt + GW'(1) : '0;
      if (finish) begin
        bus.rd_data     <= bus.spi_done ? bus.spi_rd_data : 16'hFFFF;
        bus.timeout_err <= bus.timeout_err | ~bus.spi_done;
      end
      if ((finish & ~keep) | (gap_end & ~issue)) begin
        bus.gnt0 <= 1'b0;
        bus.gnt1 <= 1'b0;
      end
      // a retained owner re-issues with the command word as it stands at gap end
      if (issue) begin
        bus.gnt0    <= ~issue_port;
        bus.gnt1    <= issue_port;
        owner       <= issue_port;
        bus.spi_cmd <= issue_port ? bus.cmd1 : bus.cmd0;
        burst_cnt   <= state == IDLE ? BW'(1) : (burst_cnt == BURST_MAX ? burst_cnt : burst_cnt + BW'(1));
        if (state == IDLE) last <= issue_port;
      end
    end
  end
endmodule
